// File: rtl/swap_src.sv
// ---------------------------------------------------------------------------
// swap_src : clocked initiator for the two-channel four-phase swap fabric.
//
// Takes one (d, d1, sel) word over a synchronous valid/ready handshake.
// For each word it raises one bundled-data request on each output channel.
// It also raises one dual-rail control token: ctl_a means pass straight and
// ctl_b means swap. It then runs the full return-to-zero cycle on all three
// channels before it will take another word.
//
// Parameters
//   N   data width of each channel
//   CW  width of the completed-transaction counter (wraps modulo 2^CW)
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   word handshake
//   in_d, in_d1         channel-0 / channel-1 payload
//   in_sel              0 = straight (ctl_a), 1 = swap (ctl_b)
//   r_o/a_o/d_o         channel-0 request, acknowledge (async), data
//   r1_o/a1_o/d1_o      channel-1 request, acknowledge (async), data
//   ctl_a/ctl_b/actl_o  control rails and control acknowledge (async)
//   cnt_o               completed four-phase transactions
//   err_o               sticky protocol-violation flag
//
// Build option
//   SWAP_SRC_SYNC_EN    when defined, each ack goes through a two-flop
//                       synchronizer (2-cycle ack latency). When undefined,
//                       each ack is registered once (1-cycle latency), which
//                       suits simulation or same-clock responders.
// ---------------------------------------------------------------------------
module swap_src #(
  parameter int N  = 1,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_d,
  input  logic [N-1:0]  in_d1,
  input  logic          in_sel,
  output logic          r_o,
  input  logic          a_o,
  output logic [N-1:0]  d_o,
  output logic          r1_o,
  input  logic          a1_o,
  output logic [N-1:0]  d1_o,
  output logic          ctl_a,
  output logic          ctl_b,
  input  logic          actl_o,
  output logic [CW-1:0] cnt_o,
  output logic          err_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_RTZ   = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  // Synchronized acknowledges.
  logic sa;
  logic sa1;
  logic sactl;

  // The ack flops are deliberately left out of reset. They must keep
  // tracking the real ack levels through a reset. That way a responder
  // still holding stale acks high keeps in_ready low afterwards.
`ifdef SWAP_SRC_SYNC_EN
  logic sa_meta;
  logic sa1_meta;
  logic sactl_meta;

  always_ff @(posedge clk) begin
    sa_meta    <= a_o;
    sa1_meta   <= a1_o;
    sactl_meta <= actl_o;
    sa         <= sa_meta;
    sa1        <= sa1_meta;
    sactl      <= sactl_meta;
  end
`else
  always_ff @(posedge clk) begin
    sa    <= a_o;
    sa1   <= a1_o;
    sactl <= actl_o;
  end
`endif

  logic [2:0] acks;
  logic [2:0] acks_prev;
  logic       acks_hi;
  logic       acks_lo;

  assign acks    = {sactl, sa1, sa};
  assign acks_hi = &acks;
  assign acks_lo = ~(|acks);

  // Previous synchronized ack levels, used to spot an ack that moves
  // the wrong way during a phase.
  always_ff @(posedge clk) begin
    acks_prev <= acks;
  end

  // Control events decoded by the FSM for the datapath below.
  logic accept;
  logic release_req;
  logic complete;
  logic err_set;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and event decode.
  // In DRIVE, an ack that falls before every ack is high is a premature
  // withdrawal. In RTZ, an ack that rises is a spurious token. Neither
  // case redirects the FSM. It keeps waiting on acks_hi / acks_lo.
  // A drop cannot happen in the same cycle as acks_hi, so the DRIVE check
  // needs no extra qualification.
  always_comb begin
    state_nx    = state;
    in_ready    = 1'b0;
    accept      = 1'b0;
    release_req = 1'b0;
    complete    = 1'b0;
    err_set     = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = acks_lo;
        if (in_valid && acks_lo) begin
          accept   = 1'b1;
          state_nx = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (|(acks_prev & ~acks)) begin
          err_set = 1'b1;
        end
        if (acks_hi) begin
          release_req = 1'b1;
          state_nx    = S_RTZ;
        end
      end
      S_RTZ: begin
        if (|(~acks_prev & acks)) begin
          err_set = 1'b1;
        end
        if (acks_lo) begin
          complete = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Requests, rails and data are set on the accept edge itself, so the
  // bundled data is valid the moment the requests rise. Exactly one rail is
  // ever set, so ctl_a & ctl_b can never be 1. The data stays on the bus
  // through RTZ and IDLE until the next accept overwrites it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_o   <= 1'b0;
      r1_o  <= 1'b0;
      ctl_a <= 1'b0;
      ctl_b <= 1'b0;
      d_o   <= '0;
      d1_o  <= '0;
    end else if (accept) begin
      r_o   <= 1'b1;
      r1_o  <= 1'b1;
      ctl_a <= ~in_sel;
      ctl_b <= in_sel;
      d_o   <= in_d;
      d1_o  <= in_d1;
    end else if (release_req) begin
      r_o   <= 1'b0;
      r1_o  <= 1'b0;
      ctl_a <= 1'b0;
      ctl_b <= 1'b0;
    end
  end

  // Transaction counter. It counts only when the return-to-zero phase
  // completes, so a reset mid-transaction never counts a token.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_o <= '0;
    end else if (complete) begin
      cnt_o <= cnt_o + CW'(1);
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_o <= 1'b0;
    end else if (err_set) begin
      err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_swap_src.sv
// ---------------------------------------------------------------------------
// tb_swap_src : self-checking bench for swap_src (N=8, CW=2).
//
// A responder answers each request channel after a programmable delay. It
// drops each ack a programmable number of cycles after that channel's
// request has fallen. The reference model tracks each word at transaction
// level, using only what the bench itself drives: the words it offers and
// how long it has held its own acks all-high or all-low. From that it
// predicts the requests, rails, data, in_ready, counter and error flag
// on every cycle.
// ---------------------------------------------------------------------------
module tb_swap_src;

  localparam int N  = 8;
  localparam int CW = 2;
`ifdef SWAP_SRC_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  in_d = '0;
  logic [N-1:0]  in_d1 = '0;
  logic          in_sel = 1'b0;
  logic          r_o;
  logic          a_o = 1'b0;
  logic [N-1:0]  d_o;
  logic          r1_o;
  logic          a1_o = 1'b0;
  logic [N-1:0]  d1_o;
  logic          ctl_a;
  logic          ctl_b;
  logic          actl_o = 1'b0;
  logic [CW-1:0] cnt_o;
  logic          err_o;

  always #5 clk = ~clk;

  swap_src #(.N(N), .CW(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_d     (in_d),
    .in_d1    (in_d1),
    .in_sel   (in_sel),
    .r_o      (r_o),
    .a_o      (a_o),
    .d_o      (d_o),
    .r1_o     (r1_o),
    .a1_o     (a1_o),
    .d1_o     (d1_o),
    .ctl_a    (ctl_a),
    .ctl_b    (ctl_b),
    .actl_o   (actl_o),
    .cnt_o    (cnt_o),
    .err_o    (err_o)
  );

  typedef struct packed {
    logic [7:0] d;
    logic [7:0] d1;
    logic       sel;
  } word_t;

  // Transaction phases as seen from outside: waiting for a word, requests
  // outstanding, returning to zero.
  typedef enum int {P_WAIT, P_REQ, P_RET} phase_t;

  word_t  send_q[$];
  word_t  cur;
  word_t  pend;
  bit     accept_pending;
  phase_t phase;
  int     cnt_exp;
  bit     err_exp;

  int       n_checks = 0;
  int       n_pass = 0;
  int       hi_run;
  int       lo_run;
  int       ack_dly[3];
  int       drop_dly;
  int       up[3];
  int       dn[3];
  logic [2:0] ack_drv;
  bit       glitch_en;
  int       glitch_at;
  int       glitch_len;

  // Count one comparison and report it if it does not match.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit exp_ready();
    return (phase == P_WAIT) && (lo_run >= LAT);
  endfunction

  // One clock cycle. Sample and check the DUT, advance the model, update
  // the responder, then drive the word interface.
  task automatic applyStimulus();
    logic [2:0] req;
    logic [2:0] nxt;
    bit         busy;
    @(negedge clk);
    if (rst) begin
      phase          = P_WAIT;
      cur            = '0;
      accept_pending = 1'b0;
      cnt_exp        = 0;
      err_exp        = 1'b0;
      checkOutput("rst_err", 32'(err_o), 32'd0);
      rst = 1'b0;
    end else if (accept_pending) begin
      phase          = P_REQ;
      cur            = pend;
      accept_pending = 1'b0;
    end else if (phase == P_REQ && hi_run >= LAT + 1) begin
      phase = P_RET;
    end else if (phase == P_RET && lo_run >= LAT + 1) begin
      phase   = P_WAIT;
      cnt_exp = (cnt_exp + 1) % (1 << CW);
      checkOutput("err_at_done", 32'(err_o), 32'(err_exp));
    end

    busy = (phase == P_REQ);
    checkOutput("r_o", 32'(r_o), 32'(busy));
    checkOutput("r1_o", 32'(r1_o), 32'(busy));
    checkOutput("ctl_a", 32'(ctl_a), 32'(busy && !cur.sel));
    checkOutput("ctl_b", 32'(ctl_b), 32'(busy && cur.sel));
    checkOutput("rails_excl", 32'(ctl_a & ctl_b), 32'd0);
    checkOutput("d_o", 32'(d_o), 32'(cur.d));
    checkOutput("d1_o", 32'(d1_o), 32'(cur.d1));
    checkOutput("cnt_o", 32'(cnt_o), 32'(cnt_exp));
    checkOutput("in_ready", 32'(in_ready), 32'(exp_ready()));

    // Responder.
    req = {ctl_a | ctl_b, r1_o, r_o};
    nxt = ack_drv;
    for (int c = 0; c < 3; c++) begin
      if (req[c]) begin
        dn[c] = 0;
        up[c]++;
        if (up[c] >= ack_dly[c]) nxt[c] = 1'b1;
      end else begin
        up[c] = 0;
        dn[c]++;
        if (dn[c] >= drop_dly) nxt[c] = 1'b0;
      end
    end
    if (glitch_en && req[1] && up[1] >= glitch_at && up[1] < glitch_at + glitch_len) begin
      if (ack_drv[1] && phase == P_REQ) err_exp = 1'b1;
      nxt[1] = 1'b0;
    end
    ack_drv = nxt;
    a_o     = ack_drv[0];
    a1_o    = ack_drv[1];
    actl_o  = ack_drv[2];
    hi_run  = (&ack_drv) ? hi_run + 1 : 0;
    lo_run  = (~|ack_drv) ? lo_run + 1 : 0;

    // Word interface: offer the head of the queue until it is taken.
    if (send_q.size() > 0) begin
      in_valid = 1'b1;
      in_d     = send_q[0].d;
      in_d1    = send_q[0].d1;
      in_sel   = send_q[0].sel;
      if (exp_ready()) begin
        pend           = send_q.pop_front();
        accept_pending = 1'b1;
      end
    end else begin
      in_valid = 1'b0;
      in_d     = 8'($urandom);
      in_d1    = 8'($urandom);
      in_sel   = 1'($urandom);
    end
  endtask

  // Step until every queued word has completed its return-to-zero cycle.
  task automatic runIdle(input int bound);
    int k;
    k = 0;
    do begin
      applyStimulus();
      k++;
    end while (!(phase == P_WAIT && send_q.size() == 0 && !accept_pending) && k < bound);
    if (!(phase == P_WAIT && send_q.size() == 0 && !accept_pending)) begin
      checkOutput("timeout", 32'd0, 32'd1);
    end
  endtask

  function automatic word_t rand_word();
    word_t w;
    w.d   = 8'($urandom);
    w.d1  = 8'($urandom);
    w.sel = 1'($urandom);
    return w;
  endfunction

  initial begin
    hi_run         = 0;
    lo_run         = 100;
    ack_drv        = 3'b000;
    ack_dly        = '{2, 2, 2};
    drop_dly       = 2;
    up             = '{0, 0, 0};
    dn             = '{0, 0, 0};
    glitch_en      = 1'b0;
    glitch_at      = 0;
    glitch_len     = 0;
    phase          = P_WAIT;
    cur            = '0;
    pend           = '0;
    accept_pending = 1'b0;
    cnt_exp        = 0;
    err_exp        = 1'b0;

    // Reset with all acks low.
    repeat (2) @(negedge clk);
    applyStimulus();
    repeat (2) applyStimulus();

    // Straight word with fixed payload.
    send_q.push_back(word_t'{d: 8'hA5, d1: 8'h3C, sel: 1'b0});
    runIdle(60);

    // Swap word, control ack 10 cycles later than the data acks.
    ack_dly = '{2, 2, 12};
    send_q.push_back(word_t'{d: 8'h5A, d1: 8'hC3, sel: 1'b1});
    runIdle(80);

    // Four words with in_valid held high throughout.
    ack_dly = '{2, 2, 2};
    for (int i = 0; i < 4; i++) send_q.push_back(rand_word());
    runIdle(200);

    // Five words with random responder timing; the counter wraps.
    for (int i = 0; i < 5; i++) begin
      ack_dly[0] = int'($urandom_range(1, 5));
      ack_dly[1] = int'($urandom_range(1, 5));
      ack_dly[2] = int'($urandom_range(1, 5));
      drop_dly   = int'($urandom_range(1, 4));
      send_q.push_back(rand_word());
      runIdle(80);
    end
    drop_dly = 2;

    // Channel-1 ack withdrawn early while waiting on the control ack.
    ack_dly    = '{2, 2, 12};
    glitch_en  = 1'b1;
    glitch_at  = 4;
    glitch_len = 4;
    send_q.push_back(rand_word());
    runIdle(80);
    glitch_en = 1'b0;
    checkOutput("err_raised", 32'(err_o), 32'd1);

    // Clean words afterwards; the error flag must stay set.
    ack_dly = '{2, 2, 2};
    for (int i = 0; i < 2; i++) send_q.push_back(rand_word());
    runIdle(100);
    checkOutput("err_sticky", 32'(err_o), 32'd1);

    // Reset while requests are out and the data acks are high.
    ack_dly = '{2, 2, 40};
    send_q.push_back(rand_word());
    repeat (8) applyStimulus();
    rst = 1'b1;
    applyStimulus();
    repeat (10) applyStimulus();
    checkOutput("post_rst_ready", 32'(in_ready), 32'd1);

    // A clean word after reset counts from zero again.
    ack_dly = '{2, 2, 2};
    send_q.push_back(rand_word());
    runIdle(60);
    repeat (2) applyStimulus();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/swap_src.md
Name: swap_src

Overview:
- Clocked initiator for the two-channel four-phase swap fabric.
- Accepts a synchronous (d, d1, sel) word on a valid/ready interface.
- Emits one bundled-data request token on each of the two output channels, plus one dual-rail control token: ctl_a = pass straight, ctl_b = swap.
- Completes the full return-to-zero cycle on all three channels before accepting the next word. It is the sender that drives a swap block's inputs and its control channel.

Parameters:
- N, 1, data width of each channel.
- CW, 8, width of the completed-transaction counter.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  synchronous word valid.
- in_ready  output  1  block can accept a word this cycle.
- in_d  input  N  channel-0 payload.
- in_d1  input  N  channel-1 payload.
- in_sel  input  1  0 = straight (ctl_a token), 1 = swap (ctl_b token).
- r_o  output  1  channel-0 request.
- a_o  input  1  channel-0 acknowledge (asynchronous).
- d_o  output  N  channel-0 bundled data.
- r1_o  output  1  channel-1 request.
- a1_o  input  1  channel-1 acknowledge (asynchronous).
- d1_o  output  N  channel-1 bundled data.
- ctl_a  output  1  control rail, straight.
- ctl_b  output  1  control rail, swap.
- actl_o  input  1  control acknowledge (asynchronous).
- cnt_o  output  CW  completed transactions, wraps modulo 2^CW.
- err_o  output  1  sticky protocol-violation flag.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE.
  - r_o=r1_o=ctl_a=ctl_b=0, d_o=d1_o=0, cnt_o=0, err_o=0.
  - Reset mid-transaction drops all requests and rails on that edge. No token is counted.
- Acks: a_o, a1_o and actl_o are each registered before use; call the results sa, sa1, sactl. Define acks_hi = sa & sa1 & sactl and acks_lo = ~(sa | sa1 | sactl).
- IDLE:
  - in_ready = acks_lo. After a reset with stale acks still high, in_ready stays 0 until all acks fall.
  - On in_valid & in_ready, the same edge registers d_o=in_d and d1_o=in_d1, sets r_o=r1_o=1, sets ctl_a=~in_sel and ctl_b=in_sel, and moves to DRIVE.
  - Data is valid at the same time as the requests (bundled data, no skew cycle).
- DRIVE:
  - Requests and the selected rail are held and in_ready=0.
  - When acks_hi: the edge clears r_o, r1_o, ctl_a and ctl_b, and moves to RTZ.
  - A channel that has already acked may stay high while the others arrive.
- RTZ:
  - All requests and rails are 0. d_o and d1_o are held unchanged until the next accept.
  - When acks_lo: cnt_o increments by 1, wrapping at 2^CW-1 to 0, and the state moves to IDLE.
  - in_ready can rise on the cycle after the return to IDLE. Minimum spacing between accepts is therefore 3 cycles plus the ack round-trips.
- Invariants:
  - ctl_a & ctl_b is never 1.
  - Outside DRIVE, r_o, r1_o and both rails are 0.
- err_o (sticky, cleared only by reset) is set when:
  - in DRIVE, a synchronized ack that was 1 returns to 0 before acks_hi (premature withdrawal); or
  - in RTZ, a synchronized ack that was 0 rises to 1.
- Violations never alter the FSM; it keeps waiting on the acks_hi / acks_lo conditions.
- Simultaneous events: in_valid held high across a transaction is accepted only in IDLE. Word k+1 is never merged into word k.

Optional Feature:
- SWAP_SRC_SYNC_EN.
- Defined: each ack passes through a 2-flop synchronizer (brute-force metastability guard). Ack-to-state latency is 2 cycles.
- Undefined: single registration, 1 cycle. Intended for simulation or for same-clock responders.
- All other behaviour is identical either way.

Test Plan:
- Reset with a_o=a1_o=actl_o=0 -> all outputs 0, in_ready=1, cnt_o=0, err_o=0.
- Accept in_d=8'hA5, in_d1=8'h3C, in_sel=0 (N=8); responder acks 2 cycles after each request and drops acks 2 cycles after the requests fall -> d_o=A5 and d1_o=3C with r_o=r1_o=ctl_a=1 and ctl_b=0. Requests drop only after all 3 acks are high. cnt_o=1 after RTZ. in_ready stays 0 throughout.
- in_sel=1 with actl_o delayed 10 cycles after a_o and a1_o -> ctl_b=1 and ctl_a=0. Requests are held all 10 extra cycles. No error.
- in_valid held high for 4 back-to-back words -> exactly 4 full four-phase cycles, cnt_o=4, and never ctl_a=ctl_b=1.
- With CW=2: 5 transactions -> cnt_o sequence 1,2,3,0,1. a1_o dropped early in DRIVE -> err_o=1 and stays 1 through later clean transactions until rst.
- rst asserted during DRIVE with acks high -> outputs 0 on the next edge. in_ready=0 until acks fall, then 1. cnt_o=0.
